// File: rtl/lbp_gen.sv
// 3x3 local binary pattern generator: reads each pixel, then its 8 neighbours, then writes one code.
// 10 cycles per interior pixel and 2 per border pixel; a write holds until lbp_ready.
module lbp_gen #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [PIX_W-1:0]  gray_data,
  input  logic [PIX_W-1:0]  thr,
  input  logic              border_en,
  input  logic              lbp_ready,
  output logic              lbp_valid,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [7:0]        lbp_data,
  output logic              finish
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0]     COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0]     COL_INT  = CW'(IMG_W - 2);
  localparam logic [RW-1:0]     ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0]     ROW_INT  = RW'(IMG_H - 2);
  localparam logic [ADDR_W-1:0] WA       = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] SKIP     = ADDR_W'(3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CENTER,
    S_NEIGH,
    S_WRITE,
    S_BORDER,
    S_DONE
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] p, p_n;
  logic [RW-1:0]     row, row_n;
  logic [CW-1:0]     col, col_n;
  logic [2:0]        k;
  logic [PIX_W-1:0]  gc;
  logic [PIX_W-1:0]  thr_q;
  logic              bord_q;
  logic [7:0]        code;
  logic              last_pix;
  logic              nxt_border;
  logic              hit;
  logic [ADDR_W-1:0] nb_addr;

  // Sum carried at PIX_W+1 bits so a large thr can never wrap into a match.
  assign hit = {1'b0, gray_data} >= ({1'b0, gc} + {1'b0, thr_q});

  always_comb begin
    case (k)
      3'd0:    nb_addr = p - WA - ONE;
      3'd1:    nb_addr = p - WA;
      3'd2:    nb_addr = p - WA + ONE;
      3'd3:    nb_addr = p - ONE;
      3'd4:    nb_addr = p + ONE;
      3'd5:    nb_addr = p + WA - ONE;
      3'd6:    nb_addr = p + WA;
      default: nb_addr = p + WA + ONE;
    endcase
  end

  always_comb begin
    row_n = row;
    col_n = col + 1'b1;
    p_n   = p + ONE;
    if (bord_q) begin
      if (col == COL_LAST) begin
        col_n = '0;
        row_n = row + 1'b1;
      end
    end else if (col == COL_INT) begin
      // Skip the right border of this row and the left border of the next.
      col_n = CW'(1);
      row_n = row + 1'b1;
      p_n   = p + SKIP;
    end
  end

  assign last_pix   = bord_q ? (row == ROW_LAST && col == COL_LAST)
                             : (row == ROW_INT && col == COL_INT);
  assign nxt_border = (row_n == '0) || (row_n == ROW_LAST) ||
                      (col_n == '0) || (col_n == COL_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    gray_addr = '0;
    case (state)
      S_IDLE:   if (gray_ready) state_n = border_en ? S_BORDER : S_CENTER;
      S_CENTER: begin
        gray_addr = p;
        state_n   = S_NEIGH;
      end
      S_NEIGH: begin
        gray_addr = nb_addr;
        if (k == 3'd7) state_n = S_WRITE;
      end
      S_BORDER: state_n = S_WRITE;
      S_WRITE: begin
        if (lbp_ready) begin
          if (last_pix)        state_n = S_DONE;
          else if (nxt_border) state_n = S_BORDER;
          else                 state_n = S_CENTER;
        end
      end
      S_DONE:   state_n = S_DONE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gray_req <= 1'b0;
      p        <= '0;
      row      <= '0;
      col      <= '0;
      k        <= '0;
      gc       <= '0;
      thr_q    <= '0;
      bord_q   <= 1'b0;
      code     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gray_ready) begin
            gray_req <= 1'b1;
            thr_q    <= thr;
            bord_q   <= border_en;
            p        <= border_en ? '0 : WA + ONE;
            row      <= border_en ? '0 : RW'(1);
            col      <= border_en ? '0 : CW'(1);
            k        <= '0;
            code     <= '0;
          end
        end
        S_CENTER: begin
          gc   <= gray_data;
          k    <= '0;
          code <= '0;
        end
        S_NEIGH: begin
          code[k] <= hit;
          k       <= k + 1'b1;
        end
        S_BORDER: code <= '0;
        S_WRITE: begin
          if (lbp_ready && !last_pix) begin
            p   <= p_n;
            row <= row_n;
            col <= col_n;
          end
        end
        default: ;
      endcase
    end
  end

  assign lbp_valid = (state == S_WRITE);
  assign finish    = (state == S_DONE);
  assign lbp_addr  = p;
  assign lbp_data  = code;

endmodule

// File: tb/tb_lbp_gen.sv
// Directed bench: 4x4 vector table, write stall, 16x16 full run and a 128x128 mid-pixel reset.
module tb_lbp_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       gray_ready = 1'b0;
  logic [7:0] thr = '0;
  logic       border_en = 1'b0;
  logic       lbp_ready = 1'b1;
  logic       pat = 1'b0;

  logic       req4, val4, fin4;
  logic [3:0] ga4, la4;
  logic [7:0] gd4, ld4;
  logic       req16, val16, fin16;
  logic [7:0] ga16, la16, ld16;
  logic       reqb, valb, finb;
  logic [13:0] gab, lab;
  logic [7:0] ldb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign gd4 = pat ? {4'b0, ga4} : 8'd10;

  lbp_gen #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .ADDR_W(4)) d4 (
    .clk(clk), .reset(reset), .gray_ready(gray_ready), .gray_req(req4),
    .gray_addr(ga4), .gray_data(gd4), .thr(thr), .border_en(border_en),
    .lbp_ready(lbp_ready), .lbp_valid(val4), .lbp_addr(la4), .lbp_data(ld4),
    .finish(fin4));

  lbp_gen #(.IMG_W(16), .IMG_H(16), .PIX_W(8), .ADDR_W(8)) d16 (
    .clk(clk), .reset(reset), .gray_ready(gray_ready), .gray_req(req16),
    .gray_addr(ga16), .gray_data(8'd10), .thr(thr), .border_en(border_en),
    .lbp_ready(lbp_ready), .lbp_valid(val16), .lbp_addr(la16), .lbp_data(ld16),
    .finish(fin16));

  lbp_gen db (
    .clk(clk), .reset(reset), .gray_ready(gray_ready), .gray_req(reqb),
    .gray_addr(gab), .gray_data(8'd10), .thr(thr), .border_en(border_en),
    .lbp_ready(lbp_ready), .lbp_valid(valb), .lbp_addr(lab), .lbp_data(ldb),
    .finish(finb));

  typedef struct {
    logic [7:0]        thr;
    logic              bord;
    logic              pat;
    int                nw;
    int                cyc;
    logic [15:0][7:0]  code;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    gray_ready = 1'b0;
    lbp_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start(input logic [7:0] t, input logic b);
    thr = t;
    border_en = b;
    gray_ready = 1'b1;
    @(negedge clk);
    gray_ready = 1'b0;
    thr = ~t;
    border_en = ~b;
  endtask

  // Interior 4x4 addresses in raster order are 5,6,9,10.
  function automatic int exp_addr4(input logic b, input int n);
    return b ? n : 4 * (1 + n / 2) + 1 + n % 2;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int cyc, nw, ea;
    do_reset();
    pat = v.pat;
    start(v.thr, v.bord);
    chk($sformatf("v%0d gray_req after start", idx), req4, 1);
    cyc = 0;
    nw = 0;
    while (!fin4 && cyc < 400) begin
      if (val4 && lbp_ready) begin
        if (nw < v.nw) begin
          ea = exp_addr4(v.bord, nw);
          chk($sformatf("v%0d w%0d addr", idx, nw), la4, ea);
          chk($sformatf("v%0d w%0d data", idx, nw), ld4, v.code[ea]);
        end
        nw++;
      end
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("v%0d write count", idx), nw, v.nw);
    chk($sformatf("v%0d cycles to finish", idx), cyc, v.cyc);
    @(negedge clk);
    chk($sformatf("v%0d valid low in done", idx), {val4, fin4}, 2'b01);
  endtask

  localparam logic [127:0] K_FF = 128'h00000000_00FFFF00_00FFFF00_00000000;
  localparam logic [127:0] K_F0 = 128'h00000000_00F0F000_00F0F000_00000000;
  localparam logic [127:0] K_E0 = 128'h00000000_00E0E000_00E0E000_00000000;
  localparam logic [127:0] K_C0 = 128'h00000000_00C0C000_00C0C000_00000000;

  initial begin
    int cyc, nw, nb, n16;
    logic [3:0] ha;
    logic [7:0] hd, last16, fb_d;
    logic [13:0] fb_a;
    logic fb_seen;

    vt[0] = '{thr: 8'd0,   bord: 1'b0, pat: 1'b0, nw: 4,  cyc: 40, code: K_FF};
    vt[1] = '{thr: 8'd1,   bord: 1'b0, pat: 1'b0, nw: 4,  cyc: 40, code: '0};
    vt[2] = '{thr: 8'd255, bord: 1'b0, pat: 1'b0, nw: 4,  cyc: 40, code: '0};
    vt[3] = '{thr: 8'd0,   bord: 1'b0, pat: 1'b1, nw: 4,  cyc: 40, code: K_F0};
    vt[4] = '{thr: 8'd3,   bord: 1'b0, pat: 1'b1, nw: 4,  cyc: 40, code: K_E0};
    vt[5] = '{thr: 8'd4,   bord: 1'b0, pat: 1'b1, nw: 4,  cyc: 40, code: K_C0};
    vt[6] = '{thr: 8'd0,   bord: 1'b1, pat: 1'b0, nw: 16, cyc: 64, code: K_FF};
    vt[7] = '{thr: 8'd2,   bord: 1'b1, pat: 1'b1, nw: 16, cyc: 64, code: K_E0};

    do_reset();
    chk("reset outputs", {req4, ga4, val4, la4, ld4, fin4}, '0);
    repeat (3) @(negedge clk);
    chk("idle without gray_ready", {req4, val4, fin4}, '0);

    for (int i = 0; i < 8; i++) run_vec(vt[i], i);

    // Sink stalls for 5 cycles on the first result.
    do_reset();
    pat = 1'b0;
    start(8'd0, 1'b0);
    cyc = 0;
    while (!val4 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("stall first valid", {val4, la4}, {1'b1, 4'd5});
    ha = la4;
    hd = ld4;
    lbp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall hold %0d", i), {val4, la4, ld4}, {1'b1, ha, hd});
    end
    lbp_ready = 1'b1;
    nw = 0;
    cyc = 0;
    while (!fin4 && cyc < 200) begin
      if (val4) begin
        chk($sformatf("stall w%0d addr/data", nw), {la4, ld4},
            {4'(exp_addr4(1'b0, nw)), 8'hFF});
        nw++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("stall write count", nw, 4);

    // 128x128: reset inside NEIGH of interior pixel 300 (p=433), then rerun.
    do_reset();
    start(8'd0, 1'b0);
    nb = 0;
    cyc = 0;
    while (nb < 300 && cyc < 5000) begin
      if (valb) nb++;
      if (nb < 300) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("big writes before reset", nb, 300);
    repeat (3) @(negedge clk);
    chk("big neigh k1 addr", gab, 14'd305);
    reset = 1'b1;
    @(negedge clk);
    chk("big mid-pixel reset", {reqb, gab, valb, lab, ldb, finb}, '0);
    reset = 1'b0;
    @(negedge clk);
    chk("big idle after reset", {reqb, valb}, '0);
    start(8'd0, 1'b0);
    n16 = 0;
    last16 = '0;
    fb_seen = 1'b0;
    fb_a = '0;
    fb_d = '0;
    cyc = 0;
    while (!fin16 && cyc < 3000) begin
      if (val16) begin
        n16++;
        last16 = la16;
      end
      if (valb && !fb_seen) begin
        fb_seen = 1'b1;
        fb_a = lab;
        fb_d = ldb;
      end
      @(negedge clk);
      cyc++;
    end
    chk("big restart first write", {fb_seen, fb_a, fb_d}, {1'b1, 14'd129, 8'hFF});
    chk("16x16 write count", n16, 196);
    chk("16x16 last addr", last16, 8'd238);
    chk("16x16 cycles", cyc, 1960);
    chk("16x16 finish", {fin16, val16}, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
